// File: rtl/ex_stage_mc.sv
// ---------------------------------------------------------------------------
// cpu_defs_pkg / ex_stage_mc
//
// Purpose:
//   Execute stage sitting between ID and MEM. Single-cycle ALU ops and an
//   optional iterative multiplier share one registered output slot. Both
//   sides use valid/ready handshakes, and a flush kills the slot and any
//   multiply in flight.
//
// Configuration macro:
//   EX_MUL_EN  defined   -> OP_MUL runs on the iterative multiplier
//                           (N = XLEN/MUL_BITS_PER_CYCLE busy cycles).
//              undefined -> no multiplier or FSM; OP_MUL completes in one
//                           cycle as an illegal op.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                kill in-flight op and output slot
//   in_valid/in_ready    ID-side handshake
//   rd_in, op_in         destination register and opcode
//   imm_in, rs1_in,
//   rs2_in               immediate and operands (rs2 doubles as store data)
//   out_valid/out_ready  MEM-side handshake
//   rd_out, op_out       registered rd and op
//   alu_result           result or effective address
//   store_data           registered rs2
//   mem_read, mem_write  load/store strobes
//   illegal_op           op was undecodable
// ---------------------------------------------------------------------------

package cpu_defs_pkg;
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
endpackage

module ex_stage_mc
  import cpu_defs_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int REG_ADDR_W         = 4,
  parameter int MUL_BITS_PER_CYCLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [3:0]            op_in,
  input  logic [XLEN-1:0]       imm_in,
  input  logic [XLEN-1:0]       rs1_in,
  input  logic [XLEN-1:0]       rs2_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [3:0]            op_out,
  output logic [XLEN-1:0]       alu_result,
  output logic [XLEN-1:0]       store_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  illegal_op
);

  localparam int SHW = $clog2(XLEN);

  // The multiplier walks the operand in equal power-of-two chunks, so a
  // width that does not split evenly is rejected at elaboration.
  if (((XLEN % MUL_BITS_PER_CYCLE) != 0) ||
      ((MUL_BITS_PER_CYCLE & (MUL_BITS_PER_CYCLE - 1)) != 0)) begin : g_badMulBits
    $error("MUL_BITS_PER_CYCLE must be a power of two dividing XLEN");
  end

  logic                  r_outValid;
  logic [REG_ADDR_W-1:0] r_rdOut;
  logic [3:0]            r_opOut;
  logic [XLEN-1:0]       r_aluResult;
  logic [XLEN-1:0]       r_storeData;
  logic                  r_memRead;
  logic                  r_memWrite;
  logic                  r_illegalOp;

  logic [XLEN-1:0]       w_aluResult;
  logic                  w_memRead;
  logic                  w_memWrite;
  logic                  w_illegal;
  logic                  w_slotFree;
  logic                  w_accept;
  logic                  w_loadSingle;

  assign out_valid  = r_outValid;
  assign rd_out     = r_rdOut;
  assign op_out     = r_opOut;
  assign alu_result = r_aluResult;
  assign store_data = r_storeData;
  assign mem_read   = r_memRead;
  assign mem_write  = r_memWrite;
  assign illegal_op = r_illegalOp;

  // The slot can take a new result when empty or when MEM drains it this cycle.
  assign w_slotFree = !r_outValid || out_ready;
  assign w_accept   = in_valid && in_ready;

  // Single-cycle decode. OP_MUL has no entry here: with the multiplier it
  // never takes this path, and without it it must fall into the illegal case.
  always_comb begin
    w_aluResult = '0;
    w_memRead   = 1'b0;
    w_memWrite  = 1'b0;
    w_illegal   = 1'b0;
    case (op_in)
      OP_ADD:   w_aluResult = rs1_in + rs2_in;
      OP_ADDI:  w_aluResult = rs1_in + imm_in;
      OP_SUB:   w_aluResult = rs1_in - rs2_in;
      OP_AND:   w_aluResult = rs1_in & rs2_in;
      OP_OR:    w_aluResult = rs1_in | rs2_in;
      OP_XOR:   w_aluResult = rs1_in ^ rs2_in;
      OP_SLL:   w_aluResult = rs1_in << rs2_in[SHW-1:0];
      OP_SRL:   w_aluResult = rs1_in >> rs2_in[SHW-1:0];
      OP_LOAD: begin
        w_aluResult = rs1_in + imm_in;
        w_memRead   = 1'b1;
      end
      OP_STORE: begin
        w_aluResult = rs1_in + imm_in;
        w_memWrite  = 1'b1;
      end
      default:  w_illegal = 1'b1;
    endcase
  end

`ifdef EX_MUL_EN
  localparam int N     = XLEN / MUL_BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [XLEN-1:0]       r_mulA;
  logic [XLEN-1:0]       r_mulB;
  logic [XLEN-1:0]       r_mulAcc;
  logic [CNT_W-1:0]      r_mulCount;
  logic                  r_mulDone;
  logic [REG_ADDR_W-1:0] r_mulRd;
  logic [XLEN-1:0]       r_mulRs2;
  logic [XLEN-1:0]       w_partial;
  logic [XLEN-1:0]       w_mulSum;
  logic [XLEN-1:0]       w_mulResult;
  logic                  w_lastIter;
  logic                  w_mulDone;
  logic                  w_mulComplete;
  logic                  w_startMul;

  assign in_ready     = !rst && !flush && (r_state == S_IDLE) && w_slotFree;
  assign w_startMul   = w_accept && (op_in == OP_MUL);
  assign w_loadSingle = w_accept && (op_in != OP_MUL);

  // Partial products for the low chunk of the shifted multiplier; r_mulA is
  // pre-shifted so the chunk lands at the right weight.
  always_comb begin
    w_partial = '0;
    for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
      if (r_mulB[i]) w_partial = w_partial + (r_mulA << i);
    end
  end

  // The final chunk is folded in on the completing edge itself so the result
  // reaches the slot N cycles after accept. Once stalled, the accumulator
  // already holds the full product and iteration stops.
  assign w_mulSum      = r_mulAcc + w_partial;
  assign w_lastIter    = (r_mulCount == CNT_W'(N - 1));
  assign w_mulDone     = (r_state == S_MUL_BUSY) && (r_mulDone || w_lastIter);
  assign w_mulResult   = r_mulDone ? r_mulAcc : w_mulSum;
  assign w_mulComplete = w_mulDone && w_slotFree && !flush;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // FSM next state; flush overrides everything else.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (w_startMul)    w_nextState = S_MUL_BUSY;
      S_MUL_BUSY: if (w_mulComplete) w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
    if (flush) w_nextState = S_IDLE;
  end

  // Multiplier datapath: latch operands on accept, then retire one chunk per
  // busy cycle until the last chunk has been added.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mulA     <= '0;
      r_mulB     <= '0;
      r_mulAcc   <= '0;
      r_mulCount <= '0;
      r_mulDone  <= 1'b0;
      r_mulRd    <= '0;
      r_mulRs2   <= '0;
    end else if (flush) begin
      r_mulCount <= '0;
      r_mulDone  <= 1'b0;
    end else if (w_startMul) begin
      r_mulA     <= rs1_in;
      r_mulB     <= rs2_in;
      r_mulAcc   <= '0;
      r_mulCount <= '0;
      r_mulDone  <= 1'b0;
      r_mulRd    <= rd_in;
      r_mulRs2   <= rs2_in;
    end else if ((r_state == S_MUL_BUSY) && !r_mulDone) begin
      r_mulAcc <= w_mulSum;
      r_mulA   <= r_mulA << MUL_BITS_PER_CYCLE;
      r_mulB   <= r_mulB >> MUL_BITS_PER_CYCLE;
      if (w_lastIter) r_mulDone  <= 1'b1;
      else            r_mulCount <= r_mulCount + CNT_W'(1);
    end
  end
`else
  assign in_ready     = !rst && !flush && w_slotFree;
  assign w_loadSingle = w_accept;
`endif

  // Output slot. Priority: reset, flush, new load, drain. A drain with a
  // simultaneous load just replaces the contents so back-to-back ops flow
  // at one per cycle; with no drain and no load everything holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid  <= 1'b0;
      r_rdOut     <= '0;
      r_opOut     <= '0;
      r_aluResult <= '0;
      r_storeData <= '0;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_illegalOp <= 1'b0;
    end else if (flush) begin
      r_outValid <= 1'b0;
    end else if (w_loadSingle) begin
      r_outValid  <= 1'b1;
      r_rdOut     <= rd_in;
      r_opOut     <= op_in;
      r_aluResult <= w_aluResult;
      r_storeData <= rs2_in;
      r_memRead   <= w_memRead;
      r_memWrite  <= w_memWrite;
      r_illegalOp <= w_illegal;
`ifdef EX_MUL_EN
    end else if (w_mulComplete) begin
      r_outValid  <= 1'b1;
      r_rdOut     <= r_mulRd;
      r_opOut     <= OP_MUL;
      r_aluResult <= w_mulResult;
      r_storeData <= r_mulRs2;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_illegalOp <= 1'b0;
`endif
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule
